// File: rtl/pc_offload_ctrl.sv
// pc_offload_ctrl
//   Sequences the fetch PC register. It chooses the next PC (sequential,
//   branch redirect or hold) and drives the PC register hold input. It also
//   runs the CGRA offload handshake: freeze the PC, stream the kernel config
//   words, pulse start, wait for done, then resume fetch after the offload
//   instruction.
//
//   Optional feature macro: PC_OFFLOAD_TIMEOUT_EN
//     defined   -> a RUN-state watchdog (TIMEOUT_CYC cycles) forces RESUME and
//                  sets a sticky err_o
//     undefined -> RUN waits indefinitely for done and err_o is tied to 0
//
// Ports
//   clk_i            : clock; all state changes on the rising edge
//   start_i          : synchronous active-low reset; while low, outputs read 0
//   pc_i             : current PC from the PC register
//   branch_taken_i   : a resolved branch or jump is taken this cycle
//   branch_target_i  : redirect target
//   load_hazard_i    : load-use hazard, so hold the PC this cycle
//   cgra_req_i       : decode holds a CGRA offload instruction
//   cgra_cfg_len_i   : number of config words, sampled when the request is accepted
//   cgra_cfg_ready_i : the CGRA accepts the current config word
//   cgra_done_i      : the CGRA kernel has finished
//   pc_next_o        : next PC to the PC register
//   hazardpc_o       : 1 = the PC register holds its value
//   flush_o          : one-cycle bubble into IF/ID
//   cgra_cfg_valid_o : config word valid
//   cgra_cfg_idx_o   : index of the current config word
//   cgra_start_o     : one-cycle kernel start pulse
//   busy_o           : an offload is in progress (state is not IDLE)
//   err_o            : sticky watchdog error
module pc_offload_ctrl #(
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned CFG_W   = 6
`ifdef PC_OFFLOAD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             load_hazard_i,
  input  logic             cgra_req_i,
  input  logic [CFG_W-1:0] cgra_cfg_len_i,
  input  logic             cgra_cfg_ready_i,
  input  logic             cgra_done_i,
  output logic [31:0]      pc_next_o,
  output logic             hazardpc_o,
  output logic             flush_o,
  output logic             cgra_cfg_valid_o,
  output logic [CFG_W-1:0] cgra_cfg_idx_o,
  output logic             cgra_start_o,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CFG    = 2'd1,
    S_RUN    = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] len_q, len_d;
  // Set on entry to RUN. It marks the start-pulse cycle, in which done is ignored.
  logic             first_q, first_d;

`ifdef PC_OFFLOAD_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  logic [31:0] pc_seq;
  assign pc_seq = pc_i + 32'(PC_STEP);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    first_d          = 1'b0;
`ifdef PC_OFFLOAD_TIMEOUT_EN
    wd_d             = wd_q;
    err_d            = err_q;
`endif
    pc_next_o        = pc_i;
    hazardpc_o       = 1'b0;
    flush_o          = 1'b0;
    cgra_cfg_valid_o = 1'b0;
    cgra_cfg_idx_o   = cnt_q;
    cgra_start_o     = 1'b0;
    busy_o           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (branch_taken_i) begin
          pc_next_o = branch_target_i;
          flush_o   = 1'b1;
        end else if (load_hazard_i) begin
          hazardpc_o = 1'b1;
        end else if (cgra_req_i) begin
          hazardpc_o = 1'b1;
          flush_o    = 1'b1;
          len_d      = cgra_cfg_len_i;
          cnt_d      = '0;
`ifdef PC_OFFLOAD_TIMEOUT_EN
          wd_d       = '0;
`endif
          if (cgra_cfg_len_i != '0) begin
            state_d = S_CFG;
          end else begin
            state_d = S_RUN;
            first_d = 1'b1;
          end
        end else begin
          pc_next_o = pc_seq;
        end
      end
      S_CFG: begin
        hazardpc_o       = 1'b1;
        cgra_cfg_valid_o = 1'b1;
        if (cgra_cfg_ready_i) begin
          // Handing over the final word moves on to RUN.
          // cnt is not advanced past it.
          if (cnt_q + CFG_W'(1) == len_q) begin
            state_d = S_RUN;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CFG_W'(1);
          end
        end
      end
      S_RUN: begin
        hazardpc_o   = 1'b1;
        cgra_start_o = first_q;
        if (cgra_done_i && !first_q) begin
          state_d = S_RESUME;
        end
`ifdef PC_OFFLOAD_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_RESUME;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: begin  // S_RESUME: step past the offload instruction
        pc_next_o = pc_seq;
        state_d   = S_IDLE;
      end
    endcase

    if (!start_i) begin
      pc_next_o        = '0;
      hazardpc_o       = 1'b0;
      flush_o          = 1'b0;
      cgra_cfg_valid_o = 1'b0;
      cgra_cfg_idx_o   = '0;
      cgra_start_o     = 1'b0;
      busy_o           = 1'b0;
    end
  end

`ifdef PC_OFFLOAD_TIMEOUT_EN
  assign err_o = start_i & err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b0;
`ifdef PC_OFFLOAD_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      first_q <= first_d;
`ifdef PC_OFFLOAD_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_offload_ctrl.sv
// tb_pc_offload_ctrl
//   Drives short directed sequences and then random traffic into
//   pc_offload_ctrl. The expected outputs come from a transaction-level model.
//   That model keeps a queue of config indices still to be sent, a flag for
//   "kernel running" with its age in cycles, and a one-shot "resume" flag.
module tb_pc_offload_ctrl;
  localparam int CW = 6;
`ifdef PC_OFFLOAD_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic          clk_i = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   pc_i = '0;
  logic          branch_taken_i = 1'b0;
  logic [31:0]   branch_target_i = '0;
  logic          load_hazard_i = 1'b0;
  logic          cgra_req_i = 1'b0;
  logic [CW-1:0] cgra_cfg_len_i = '0;
  logic          cgra_cfg_ready_i = 1'b0;
  logic          cgra_done_i = 1'b0;
  logic [31:0]   pc_next_o;
  logic          hazardpc_o, flush_o, cgra_cfg_valid_o, cgra_start_o, busy_o, err_o;
  logic [CW-1:0] cgra_cfg_idx_o;

  pc_offload_ctrl #(
    .PC_STEP(4),
    .CFG_W(CW)
`ifdef PC_OFFLOAD_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk_i(clk_i), .start_i(start_i), .pc_i(pc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .load_hazard_i(load_hazard_i), .cgra_req_i(cgra_req_i),
    .cgra_cfg_len_i(cgra_cfg_len_i), .cgra_cfg_ready_i(cgra_cfg_ready_i),
    .cgra_done_i(cgra_done_i), .pc_next_o(pc_next_o), .hazardpc_o(hazardpc_o),
    .flush_o(flush_o), .cgra_cfg_valid_o(cgra_cfg_valid_o),
    .cgra_cfg_idx_o(cgra_cfg_idx_o), .cgra_start_o(cgra_start_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  int m_cfg[$];     // config indices still to be handed to the CGRA
  bit m_run   = 0;  // kernel started and not yet finished
  int m_age   = 0;  // cycles already spent running
  bit m_res   = 0;  // one resume cycle pending
  bit m_err   = 0;

  task automatic cyc(input bit st, input bit br, input logic [31:0] tgt,
                     input bit lh, input bit rq, input int len,
                     input bit rdy, input bit dn, input logic [31:0] pc);
    logic [31:0] e_pc;
    bit e_hz, e_fl, e_v, e_st, e_busy;
    int e_idx;
    @(negedge clk_i);
    start_i = st; branch_taken_i = br; branch_target_i = tgt;
    load_hazard_i = lh; cgra_req_i = rq; cgra_cfg_len_i = CW'(len);
    cgra_cfg_ready_i = rdy; cgra_done_i = dn; pc_i = pc;
    #1;
    e_pc = pc; e_hz = 0; e_fl = 0; e_v = 0; e_st = 0; e_idx = 0;
    e_busy = m_res || m_run || (m_cfg.size() != 0);
    if (!st) begin
      e_pc = 0; e_busy = 0;
    end else if (m_res) begin
      e_pc = pc + 32'd4;
    end else if (m_cfg.size() != 0) begin
      e_hz = 1; e_v = 1; e_idx = m_cfg[0];
    end else if (m_run) begin
      e_hz = 1; e_st = (m_age == 0);
    end else if (br) begin
      e_pc = tgt; e_fl = 1;
    end else if (lh) begin
      e_hz = 1;
    end else if (rq) begin
      e_hz = 1; e_fl = 1;
    end else begin
      e_pc = pc + 32'd4;
    end
    check("pc_next", pc_next_o, e_pc);
    check("hazardpc", {31'd0, hazardpc_o}, {31'd0, e_hz});
    check("flush", {31'd0, flush_o}, {31'd0, e_fl});
    check("cfg_valid", {31'd0, cgra_cfg_valid_o}, {31'd0, e_v});
    if (e_v) check("cfg_idx", {26'd0, cgra_cfg_idx_o}, e_idx);
    check("start", {31'd0, cgra_start_o}, {31'd0, e_st});
    check("busy", {31'd0, busy_o}, {31'd0, e_busy});
    check("err", {31'd0, err_o}, {31'd0, (st && m_err)});
    $display("cyc t=%0t st=%0b br=%0b lh=%0b rq=%0b len=%0d rdy=%0b dn=%0b pc=%h -> pcn=%h hz=%0b fl=%0b v=%0b idx=%0d go=%0b busy=%0b err=%0b",
             $time, st, br, lh, rq, len, rdy, dn, pc, pc_next_o, hazardpc_o, flush_o,
             cgra_cfg_valid_o, cgra_cfg_idx_o, cgra_start_o, busy_o, err_o);
    @(posedge clk_i);
    if (!st) begin
      m_cfg.delete(); m_run = 0; m_age = 0; m_res = 0; m_err = 0;
    end else if (m_res) begin
      m_res = 0;
    end else if (m_cfg.size() != 0) begin
      if (rdy) begin
        void'(m_cfg.pop_front());
        if (m_cfg.size() == 0) begin m_run = 1; m_age = 0; end
      end
    end else if (m_run) begin
      if (dn && m_age > 0) begin
        m_run = 0; m_res = 1;
      end
`ifdef PC_OFFLOAD_TIMEOUT_EN
      else if (m_age + 1 == TO) begin
        m_run = 0; m_res = 1; m_err = 1;
      end
`endif
      else m_age++;
    end else if (!br && !lh && rq) begin
      for (int i = 0; i < len; i++) m_cfg.push_back(i);
      if (len == 0) begin m_run = 1; m_age = 0; end
    end
  endtask

  localparam logic [31:0] T = 32'h200;

  initial begin
    // reset
    cyc(0, 0, T, 0, 0, 0, 0, 0, 32'h100);
    cyc(0, 1, T, 1, 1, 3, 1, 1, 32'h100);
    // sequential and wrap
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h100);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    // branch wins over hazard and request
    cyc(1, 1, T, 1, 1, 3, 0, 0, 32'h300);
    cyc(1, 0, T, 1, 1, 3, 0, 0, 32'h300);
    // offload len=3, ready stalled on idx1
    cyc(1, 0, T, 0, 1, 3, 0, 0, 32'h400);
    cyc(1, 0, T, 0, 0, 0, 1, 1, 32'h400);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h400);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h400);
    cyc(1, 0, T, 0, 0, 0, 1, 0, 32'h400);
    cyc(1, 0, T, 0, 0, 0, 1, 0, 32'h400);
    for (int i = 0; i < 4; i++) cyc(1, 1, T, 1, 1, 2, 0, 0, 32'h400);
    cyc(1, 0, T, 0, 0, 0, 0, 1, 32'h400);
    cyc(1, 0, T, 0, 1, 1, 0, 0, 32'h400);
    cyc(1, 0, T, 0, 1, 1, 0, 0, 32'h404);
    // len=0: done in the start cycle is ignored
    cyc(1, 0, T, 0, 1, 0, 0, 0, 32'h500);
    cyc(1, 0, T, 0, 0, 0, 0, 1, 32'h500);
    cyc(1, 0, T, 0, 0, 0, 0, 1, 32'h500);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h500);
    // reset while idx2 is on offer, then a new request starts again at idx0
    cyc(1, 0, T, 0, 1, 4, 0, 0, 32'h600);
    cyc(1, 0, T, 0, 0, 0, 1, 0, 32'h600);
    cyc(1, 0, T, 0, 0, 0, 1, 0, 32'h600);
    cyc(0, 0, T, 0, 0, 0, 0, 0, 32'h600);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h600);
    cyc(1, 0, T, 0, 1, 2, 0, 0, 32'h600);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h600);
    cyc(1, 0, T, 0, 0, 0, 1, 0, 32'h600);
    // no done for 12 cycles; the watchdog fires only when it is enabled
    cyc(1, 0, T, 0, 1, 0, 0, 0, 32'h700);
    for (int i = 0; i < 12; i++) cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h700);
    cyc(1, 0, T, 0, 0, 0, 0, 1, 32'h700);
    cyc(1, 0, T, 0, 1, 1, 1, 0, 32'h800);
    for (int i = 0; i < 12; i++) cyc(1, 0, T, 0, 0, 0, 1, 0, 32'h800);
    cyc(1, 0, T, 0, 0, 0, 0, 1, 32'h800);
    cyc(1, 0, T, 0, 0, 0, 0, 0, 32'h800);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 7) == 0), $urandom,
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4)),
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 5) == 0),
          rpc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
